// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus transmit sequencer feeding a uart_tx serializer.
// Producers write bytes at clock rate; the sequencer pops one byte per frame,
// pulses tx_start, and waits on tx_busy before sending the next one.
// Optional build macro UART_TX_FIFO_CRLF_EN: expand each LF into a CR+LF pair.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    wait_cnt;
    state_t        state, state_nxt;
    logic          wr_acc;
    logic          send;       // IDLE->WAIT_BUSY transition this cycle
    logic          pop;        // head entry leaves the FIFO this cycle
    logic [7:0]    head;
    logic [7:0]    send_byte;

    // full/empty come from the registered count, so a slot freed by a pop
    // only becomes writable on the following cycle
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = wr_en && !full;
    assign head   = mem[rd_ptr];

`ifdef UART_TX_FIFO_CRLF_EN
    logic cr_sent;
    logic lf_head;

    // An LF at the head goes out as CR first without leaving the FIFO
    assign lf_head   = (head == 8'h0A) && !cr_sent;
    assign send_byte = lf_head ? 8'h0D : head;
    assign pop       = send && !lf_head;

    // Remember that the CR half of a CR+LF pair has gone out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cr_sent <= 1'b0;
        else if (send) cr_sent <= lf_head;
    end
`else
    assign send_byte = head;
    assign pop       = send;
`endif

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc)         wr_ptr   <= wr_ptr + AW'(1);
            if (pop)            rd_ptr   <= rd_ptr + AW'(1);
            if (wr_en && full)  overflow <= 1'b1;
            case ({wr_acc, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; send marks the cycle a frame is launched
    always_comb begin
        state_nxt = state;
        send      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    send      = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Give up waiting if the transmitter never acknowledged the start
                if (tx_busy)               state_nxt = WAIT_DONE;
                else if (wait_cnt == 3'd4) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lost-start timer: counts idle cycles spent waiting for tx_busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             wait_cnt <= '0;
        else if (send)                          wait_cnt <= '0;
        else if (state == WAIT_BUSY && !tx_busy) wait_cnt <= wait_cnt + 3'd1;
    end

    // Registered start pulse and held output byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= send;
            if (send) tx_data <= send_byte;
        end
    end

endmodule
